uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Frame sequencer for the UART receiver. Owns the oversampling edge/bit counters and the RX FSM.
//  Enables sampler, start/parity/stop checkers and deserializer at the right edge of each bit.
//  Emits a one-clock data_valid for each frame that has no error. Sits between RX_IN and the RX checker/deser datapath.
// PARAMETERS
//  DATA_W   8   data bits per frame (bit_cnt width = $clog2(DATA_W+3))
// PORTS
//  clk          in   1  receiver oversampling clock
//  ARSTn        in   1  asynchronous active-low reset
//  RX_IN        in   1  serial line, idle high
//  PAR_EN       in   1  parity bit present in frame
//  Prescale     in   6  oversampling ratio; legal 8/16/32
//  strt_glitch  in   1  from start checker, valid from (P>>1)+3 onward
//  par_err      in   1  from parity checker
//  stp_err      in   1  from stop checker
//  edge_cnt     out  5  oversample index within current bit, 0..P-1
//  bit_cnt      out  4  bit index within frame (0 = start bit)
//  dat_samp_en  out  1  enable majority sampler
//  strt_chk_en  out  1  start-bit check enable
//  par_chk_en   out  1  parity check enable
//  stp_chk_en   out  1  stop check enable
//  deser_en     out  1  one-clock shift strobe to deserializer
//  data_valid   out  1  one-clock pulse: frame good
// BEHAVIOUR
//  Reset: state=IDLE, edge_cnt=0, bit_cnt=0, all enables 0, data_valid 0, err flag 0, P latch=8.
//  P = Prescale latched on IDLE->START. Changes mid-frame are ignored. Prescale <8 or not a power of 2 -> P=8.
//  EOB (end of bit) = (edge_cnt==P-1). edge_cnt runs in every non-IDLE state and wraps to 0 at EOB.
//    bit_cnt increments at EOB. Both are cleared in IDLE.
//  MID = (edge_cnt==(P>>1)+2), i.e. the checker sample point.
//  All outputs are registered. They change on the clk edge that enters/leaves a state.
//  States:
//   IDLE:   RX_IN==0 -> START. Clear err flag.
//   START:  strt_chk_en=1. At EOB: strt_glitch=1 -> IDLE (no data_valid), else -> DATA.
//   DATA:   deser_en=1 for the single cycle after MID of each data bit.
//           At EOB with bit_cnt==DATA_W -> PARITY if PAR_EN, else STOP.
//   PARITY: par_chk_en=1. par_err sampled at EOB: set err flag. Always -> STOP (keeps frame alignment).
//   STOP:   stp_chk_en=1. At EOB: data_valid<=~(stp_err|err flag).
//           Next state: RX_IN==0 -> START (back-to-back frame; P relatched, counters cleared), else IDLE.
//  dat_samp_en=1 in every state except IDLE.
//  PAR_EN is latched with P. Mid-frame changes are ignored.
//  ARSTn low mid-frame: immediate return to reset values. No data_valid for the aborted frame.
//  Glitch on RX_IN while in IDLE shorter than MID is rejected through START/strt_glitch.
//  The FSM never depends on RX_IN outside IDLE and STOP-EOB.
// STRUCTURE
//  Shared package uart_pkg: state encoding localparams (IDLE/START/DATA/PARITY/STOP),
//    legal prescale constants, DATA_W default.
//  One sub-module, uart_rx_edge_bit_cnt: edge_cnt/bit_cnt with enable, P input, EOB output.
//  Top: FSM, P/PAR_EN latches, error flag, output registers.
// TESTING
//  1 P=8, PAR_EN=0, frame 0xA5: data_valid=1 for exactly 1 clk at edge 80 after the start edge;
//    deser_en pulses 8 times, 8 clk apart.
//  2 P=16, PAR_EN=1, good even parity: parity state entered; data_valid at edge 176; par_chk_en high 16 clk.
//  3 P=8, RX_IN low 3 clk then high, strt_glitch=1: FSM returns to IDLE at edge 8.
//    No deser_en, no data_valid.
//  4 P=32, PAR_EN=1, par_err=1 at parity EOB: stop still processed; data_valid stays 0.
//    Next good frame valid again.
//  5 P=8, two back-to-back frames with no idle gap: two data_valid pulses exactly 80 clk apart.
//    Prescale changed to 16 mid-frame 1 takes effect on frame 2 only.
//  6 Assert ARSTn during DATA bit 4: all outputs 0 in the same cycle.
//    Clean frame after release received normally. Also P=5 behaves as P=8.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, legal
// oversampling ratios and the default frame data width.
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PRESCALE_W = 6;
  localparam int EDGE_W     = 5;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_START  = 3'd1;
  localparam logic [2:0] ENC_DATA   = 3'd2;
  localparam logic [2:0] ENC_PARITY = 3'd3;
  localparam logic [2:0] ENC_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ENC_IDLE,
    START  = ENC_START,
    DATA   = ENC_DATA,
    PARITY = ENC_PARITY,
    STOP   = ENC_STOP
  } rx_state_e;

  // Anything other than a supported ratio falls back to 8x oversampling.
  function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter. edge_cnt wraps at P-1
// (end of bit) and bit_cnt advances on that wrap.
module uart_rx_edge_bit_cnt
  import uart_pkg::*;
#(
  parameter int BIT_W = 4
) (
  input  logic                  clk,
  input  logic                  ARSTn,
  input  logic                  cnt_en,
  input  logic                  cnt_clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [EDGE_W-1:0]     edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  eob
);

  logic [EDGE_W-1:0] edge_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;

  assign eob      = ({1'b0, edge_cnt_reg} == (prescale - 6'd1));
  assign edge_cnt = edge_cnt_reg;
  assign bit_cnt  = bit_cnt_reg;

  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else if (cnt_clr) begin
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else if (cnt_en) begin
      if (eob) begin
        edge_cnt_reg <= '0;
        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
      end else begin
        edge_cnt_reg <= edge_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: RX FSM, latched frame configuration, error
// flag and registered enables for the sampler, checkers and deserializer.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  localparam int BIT_W  = $clog2(DATA_W + 3)
) (
  input  logic                  clk,
  input  logic                  ARSTn,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [EDGE_W-1:0]     edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  dat_samp_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  deser_en,
  output logic                  data_valid
);

  rx_state_e             state_reg, state_next;
  logic [PRESCALE_W-1:0] p_reg;
  logic                  par_en_reg;
  logic                  err_reg;
  logic                  dat_samp_en_reg, strt_chk_en_reg, par_chk_en_reg, stp_chk_en_reg;
  logic                  deser_en_reg, data_valid_reg;
  logic                  eob, cnt_en, cnt_clr, cfg_latch;
  logic [EDGE_W-1:0]     mid;

  assign mid = p_reg[PRESCALE_W-1:1] + 5'd2;

  // Counters are cleared on the same edge that enters IDLE or restarts a
  // back-to-back frame, so a new frame always starts at edge 0 / bit 0.
  assign cnt_en    = (state_reg != IDLE);
  assign cnt_clr   = (state_next == IDLE) || ((state_reg == STOP) && eob);
  assign cfg_latch = (state_next == START) && (state_reg != START);

  uart_rx_edge_bit_cnt #(
    .BIT_W (BIT_W)
  ) u_cnt (
    .clk      (clk),
    .ARSTn    (ARSTn),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .prescale (p_reg),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .eob      (eob)
  );

  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (!RX_IN) state_next = START;
      START:  if (eob) state_next = strt_glitch ? IDLE : DATA;
      DATA:   if (eob && (bit_cnt == BIT_W'(DATA_W))) state_next = par_en_reg ? PARITY : STOP;
      PARITY: if (eob) state_next = STOP;
      STOP:   if (eob) state_next = RX_IN ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      p_reg           <= PRESCALE_8;
      par_en_reg      <= 1'b0;
      err_reg         <= 1'b0;
      dat_samp_en_reg <= 1'b0;
      strt_chk_en_reg <= 1'b0;
      par_chk_en_reg  <= 1'b0;
      stp_chk_en_reg  <= 1'b0;
      deser_en_reg    <= 1'b0;
      data_valid_reg  <= 1'b0;
    end else begin
      dat_samp_en_reg <= (state_next != IDLE);
      strt_chk_en_reg <= (state_next == START);
      par_chk_en_reg  <= (state_next == PARITY);
      stp_chk_en_reg  <= (state_next == STOP);
      deser_en_reg    <= (state_reg == DATA) && (edge_cnt == mid);
      data_valid_reg  <= (state_reg == STOP) && eob && !(stp_err || err_reg);
      // A parity error from one frame must not leak into a back-to-back successor.
      if ((state_reg == IDLE) || (state_next == START))
        err_reg <= 1'b0;
      else if ((state_reg == PARITY) && eob && par_err)
        err_reg <= 1'b1;
      if (cfg_latch) begin
        p_reg      <= legal_prescale(Prescale);
        par_en_reg <= PAR_EN;
      end
    end
  end

  assign dat_samp_en = dat_samp_en_reg;
  assign strt_chk_en = strt_chk_en_reg;
  assign par_chk_en  = par_chk_en_reg;
  assign stp_chk_en  = stp_chk_en_reg;
  assign deser_en    = deser_en_reg;
  assign data_valid  = data_valid_reg;

endmodule
